// File: rtl/byte_fetch_sequencer.sv
// Fetches a 32-bit word as four byte reads and presents it as four registered byte lanes.
// IDLE: waiting for start | FETCH: byte reads in flight | HOLD: word presented until accepted
module byte_fetch_sequencer #(
    parameter int ADDR_W     = 32,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        byte_1,
    output logic [7:0]        byte_2,
    output logic [7:0]        byte_3,
    output logic [7:0]        byte_4,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_valid,
    input  logic              word_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic              pend;
    logic [ADDR_W-1:0] start_base;

    assign start_base = {start_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            base       <= '0;
            pend       <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            byte_1     <= 8'h00;
            byte_2     <= 8'h00;
            byte_3     <= 8'h00;
            byte_4     <= 8'h00;
            word_addr  <= '0;
            word_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base     <= start_base;
                        cnt      <= 2'd0;
                        pend     <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= start_base;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        if (start) begin
                            base     <= start_base;
                            cnt      <= 2'd0;
                            pend     <= 1'b0;
                            mem_addr <= start_base;
                        end else if (pend) begin
                            // byte belonged to the old base; base already holds the redirect target
                            cnt      <= 2'd0;
                            pend     <= 1'b0;
                            mem_addr <= base;
                        end else begin
                            unique case (cnt)
                                2'd0: byte_4 <= mem_rdata;
                                2'd1: byte_3 <= mem_rdata;
                                2'd2: byte_2 <= mem_rdata;
                                2'd3: byte_1 <= mem_rdata;
                                default: ;
                            endcase
                            if (cnt == 2'd3) begin
                                cnt        <= 2'd0;
                                mem_req    <= 1'b0;
                                word_valid <= 1'b1;
                                word_addr  <= base;
                                state      <= HOLD;
                            end else begin
                                cnt      <= cnt + 2'd1;
                                mem_addr <= base + {{(ADDR_W-2){1'b0}}, cnt} + ADDR_W'(1);
                            end
                        end
                    end else if (start) begin
                        // request stays up with its address; the in-flight byte is dropped on ack
                        base <= start_base;
                        pend <= 1'b1;
                    end
                end
                HOLD: begin
                    if (start) begin
                        word_valid <= 1'b0;
                        base       <= start_base;
                        cnt        <= 2'd0;
                        pend       <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_addr   <= start_base;
                        state      <= FETCH;
                    end else if (word_ready) begin
                        word_valid <= 1'b0;
                        if (CONTINUOUS) begin
                            base     <= base + ADDR_W'(4);
                            cnt      <= 2'd0;
                            mem_req  <= 1'b1;
                            mem_addr <= base + ADDR_W'(4);
                            state    <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_fetch_sequencer.sv
// Directed bench: a continuous-fetch instance plus a single-shot instance against a byte memory model.
module tb_byte_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'h0;
    logic        word_ready = 1'b0;

    logic        busy, mem_req, mem_ack, word_valid;
    logic [31:0] mem_addr, word_addr;
    logic [7:0]  mem_rdata, byte_1, byte_2, byte_3, byte_4;

    logic        n_busy, n_mem_req, n_mem_ack, n_word_valid;
    logic [31:0] n_mem_addr, n_word_addr;
    logic [7:0]  n_mem_rdata, n_byte_1, n_byte_2, n_byte_3, n_byte_4;

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'hA0;
            32'h103: return 8'h00;
            default: return a[7:0] + 8'h40;
        endcase
    endfunction

    assign mem_ack     = mem_req && !stall && (wcnt >= wait_cfg);
    assign mem_rdata   = mem_byte(mem_addr);
    assign n_mem_ack   = n_mem_req;
    assign n_mem_rdata = mem_byte(n_mem_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    byte_fetch_sequencer #(.ADDR_W(32), .CONTINUOUS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .byte_1(byte_1), .byte_2(byte_2), .byte_3(byte_3), .byte_4(byte_4),
        .word_addr(word_addr), .word_valid(word_valid), .word_ready(word_ready)
    );

    byte_fetch_sequencer #(.ADDR_W(32), .CONTINUOUS(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .busy(n_busy),
        .mem_req(n_mem_req), .mem_addr(n_mem_addr), .mem_ack(n_mem_ack), .mem_rdata(n_mem_rdata),
        .byte_1(n_byte_1), .byte_2(n_byte_2), .byte_3(n_byte_3), .byte_4(n_byte_4),
        .word_addr(n_word_addr), .word_valid(n_word_valid), .word_ready(word_ready)
    );

    typedef struct {
        logic        start;
        logic [31:0] addr;
        logic        ready;
        logic        req;
        logic [31:0] maddr;
        logic        valid;
        logic [31:0] waddr;
        logic [31:0] word;
        logic        busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " bytes"}, {byte_1, byte_2, byte_3, byte_4}, 32'd0);
        chk({tag, " word_addr"}, word_addr, 32'd0);
        chk({tag, " word_valid"}, {31'd0, word_valid}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_zero(tag);
        rst_n = 1'b1;
    endtask

    // zero-wait fetch of 0x100 on both instances, word_ready high throughout
    task automatic run_first(input string tag);
        word_ready = 1'b1;
        start      = 1'b1;
        start_addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk({tag, " req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, " addr"}, mem_addr, 32'h100 + 32'(c - 1));
            chk({tag, " nc_addr"}, n_mem_addr, 32'h100 + 32'(c - 1));
            chk({tag, " valid_early"}, {31'd0, n_word_valid}, 32'd0);
            @(negedge clk);
        end
        chk({tag, " nc_valid"}, {31'd0, n_word_valid}, 32'd1);
        chk({tag, " nc_word"}, {n_byte_1, n_byte_2, n_byte_3, n_byte_4}, 32'h00A00513);
        chk({tag, " nc_waddr"}, n_word_addr, 32'h100);
        chk({tag, " valid"}, {31'd0, word_valid}, 32'd1);
        chk({tag, " word"}, {byte_1, byte_2, byte_3, byte_4}, 32'h00A00513);
        @(negedge clk);
        chk({tag, " nc_idle_busy"}, {31'd0, n_busy}, 32'd0);
        chk({tag, " nc_idle_valid"}, {31'd0, n_word_valid}, 32'd0);
        chk({tag, " nc_idle_req"}, {31'd0, n_mem_req}, 32'd0);
    endtask

    vec_t tbl[17];

    initial begin
        //           start addr     rdy req maddr     vld waddr     word           busy
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h101, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h102, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00A00513, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00A00513, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00A00513, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00A00513, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00A00513, 1'b1};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 32'h00A00513, 1'b1};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[12] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h105, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h106, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[14] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h107, 1'b0, 32'h0,   32'h0,        1'b1};
        tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 32'h47464544, 1'b1};
        tbl[16] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   32'h0,        1'b1};

        @(negedge clk);
        do_reset("reset");

        // zero-wait continuous fetch with 5 cycles of backpressure
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("tbl%0d req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
            chk($sformatf("tbl%0d valid", i), {31'd0, word_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            if (tbl[i].req) chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].maddr);
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d word", i), {byte_1, byte_2, byte_3, byte_4}, tbl[i].word);
                chk($sformatf("tbl%0d word_addr", i), word_addr, tbl[i].waddr);
            end
            start      = tbl[i].start;
            start_addr = tbl[i].addr;
            word_ready = tbl[i].ready;
            @(negedge clk);
        end

        do_reset("rst_fetch");
        run_first("first");

        // two wait states per byte
        do_reset("rst_pre_wait");
        wait_cfg   = 2;
        word_ready = 1'b0;
        start      = 1'b1;
        start_addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("wait c%0d addr", c), mem_addr, 32'h100 + 32'((c - 1) / 3));
            chk($sformatf("wait c%0d valid", c), {31'd0, word_valid}, 32'd0);
            @(negedge clk);
        end
        chk("wait c13 valid", {31'd0, word_valid}, 32'd1);
        chk("wait c13 word", {byte_1, byte_2, byte_3, byte_4}, 32'h00A00513);
        wait_cfg = 0;
        do_reset("rst_hold");
        run_first("after_rst");

        // misaligned start near the top of the address space
        do_reset("rst_pre_wrap");
        word_ready = 1'b1;
        start      = 1'b1;
        start_addr = 32'hFFFF_FFFE;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("wrap c%0d addr", c), mem_addr, 32'hFFFF_FFFC + 32'(c - 1));
            @(negedge clk);
        end
        chk("wrap word_addr", word_addr, 32'hFFFF_FFFC);
        chk("wrap word", {byte_1, byte_2, byte_3, byte_4}, 32'h3F3E3D3C);
        @(negedge clk);
        chk("wrap next req", {31'd0, mem_req}, 32'd1);
        chk("wrap next addr", mem_addr, 32'h0);

        // redirect while the third byte is stalled
        do_reset("rst_pre_redir");
        word_ready = 1'b1;
        start      = 1'b1;
        start_addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("redir stalled addr", mem_addr, 32'h102);
        stall      = 1'b1;
        start      = 1'b1;
        start_addr = 32'h200;
        @(negedge clk);
        start = 1'b0;
        chk("redir hold req", {31'd0, mem_req}, 32'd1);
        chk("redir hold addr", mem_addr, 32'h102);
        @(negedge clk);
        stall = 1'b0;
        chk("redir hold2 addr", mem_addr, 32'h102);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("redir addr %0d", c), mem_addr, 32'h200 + 32'(c));
            chk($sformatf("redir no_valid %0d", c), {31'd0, word_valid}, 32'd0);
            @(negedge clk);
        end
        chk("redir valid", {31'd0, word_valid}, 32'd1);
        chk("redir word_addr", word_addr, 32'h200);
        chk("redir word", {byte_1, byte_2, byte_3, byte_4}, 32'h43424140);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
